// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the MIPS datapath and the HI/LO multiply/divide unit.
// The datapath drives the master side; the unit presents the slave side.
interface mul_div_unit_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit: one bit per cycle, signed ops run on
// magnitudes and fix the result signs in a single FINISH cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_divz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sgn_in;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_sgn_in = ~bus.op[0];
  assign w_a_abs  = (w_sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_abs  = (w_sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, r_opnd};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  // A zero divisor leaves the remainder equal to |a|, so the dividend-sign fix restores a.
  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_divz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_neg_q <= w_sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r <= w_sgn_in & bus.a[WIDTH-1];
            r_divz  <= bus.op[1] & (bus.b == '0);
            r_opnd  <= bus.op[1] ? w_b_abs : w_a_abs;
            r_acc   <= bus.op[1] ? {{WIDTH{1'b0}}, w_a_abs} : {{WIDTH{1'b0}}, w_b_abs};
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            if (bus.hi_we) r_hi <= bus.a;
            if (bus.lo_we) r_lo <= bus.a;
          end
        end
        CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          if (r_cnt == '0) r_state <= FINISH;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FINISH: begin
          if (r_op[1]) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random ops against a
// plain-arithmetic reference model; a separate monitor checks every done pulse.
module tb_mul_div_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  res_t         q[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t        r;
    logic [63:0] p;
    longint      sa, sb;
    int          ia, ib;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        r  = {p[63:32], p[31:0]};
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        r = {p[63:32], p[31:0]};
      end
      2'b10: begin
        if (b == 0)                                    r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          ia = a; ib = b;
          r = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Monitor: pops an expectation on each done pulse; also checks busy length and done width.
  int busy_cnt = 0;
  logic prev_done = 1'b0;
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("done_width", {31'b0, bus.done}, 32'd0);
        if (bus.done) begin
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: hi=%h lo=%h with empty scoreboard", bus.hi, bus.lo);
          end else begin
            e = q.pop_front();
            check("result_hi", bus.hi, e.hi);
            check("result_lo", bus.lo, e.lo);
            check("busy_cycles", 32'(busy_cnt), 32'd33);
            check("busy_at_done", {31'b0, bus.busy}, 32'd0);
          end
          busy_cnt = 0;
        end else if (bus.busy) busy_cnt++;
        else busy_cnt = 0;
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        failures++;
        $display("FAIL busy_timeout: busy still %b after %0d cycles", bus.busy, n);
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        failures++;
        $display("FAIL drain_timeout: %0d results outstanding, got none", q.size());
        q.delete();
        return;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic lo_we);
    res_t r;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.lo_we = lo_we;
    r = model(op, a, b);
    q.push_back(r);
    m_hi = r.hi;
    m_lo = r.lo;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;

    // Directed cases from the test plan
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'b11, 32'd100, 32'd7, 1'b1);      // start with lo_we: MTLO must be dropped
    issue(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    drain();

    // MTHI alone, then MTHI+MTLO together, in IDLE
    @(negedge clk);
    bus.hi_we = 1'b1; bus.a = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    m_hi = 32'hAAAA_5555;
    check("mthi_hi", bus.hi, m_hi);
    check("mthi_lo_kept", bus.lo, m_lo);
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.a = 32'h1357_2468;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mthilo_hi", bus.hi, 32'h1357_2468);
    check("mthilo_lo", bus.lo, 32'h1357_2468);

    // start/hi_we/lo_we while busy are ignored
    issue(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("busy_ignore_hi", bus.hi, m_hi);
    check("busy_ignore_lo", bus.lo, m_lo);

    // Random operations, biased toward zero divisors and small operands
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      issue(rop, ra, rb, 1'b0);
    end
    drain();

    // Reset asserted mid-CALC aborts the op with no done pulse afterwards
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);
    check("post_abort_hi", bus.hi, 32'd0);
    check("post_abort_lo", bus.lo, 32'd0);

    // Unit is usable again after the abort
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit beside the single-cycle ALU in the MIPS datapath.
- Takes the register-file operands (srca, srcb) and produces the HI/LO pair that MFHI/MFLO read in place of the ALU's combinational hi/lo.
- Iterative radix-2 engine, one bit per cycle; the control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and result width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  operand A (multiplicand or dividend), srca.
- b  input  WIDTH  operand B (multiplier or divisor), srcb.
- hi_we  input  1  MTHI: write a into HI.
- lo_we  input  1  MTLO: write a into LO.
- busy  output  1  operation in progress; datapath must stall.
- done  output  1  one-cycle pulse when HI/LO receive a new result.
- hi  output  WIDTH  HI register (product high word or remainder).
- lo  output  WIDTH  LO register (product low word or quotient).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Reset asserted mid-operation aborts it; HI/LO are cleared and no done pulse occurs.
- States: IDLE, CALC, FINISH. All outputs are registered.
- IDLE:
  - If start=1 at an edge: latch op, a, b, a sign flag and a zero-divisor flag.
  - For signed ops, latch |a| and |b|; for unsigned ops, latch the raw values.
  - Set counter=WIDTH-1, busy=1, next state CALC. HI/LO keep their old values.
  - If start=0: hi_we=1 loads hi<=a and lo_we=1 loads lo<=a on that edge; both may fire together.
  - If start=1 and hi_we/lo_we are asserted in the same cycle, start wins and the writes are dropped.
- CALC: exactly WIDTH cycles (counter WIDTH-1 down to 0); after the edge with counter=0, next state is FINISH.
  - Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle. Remainder and quotient are held in an internal 2*WIDTH register.
- FINISH: one cycle; at its closing edge:
  - Write hi/lo, set done=1 for exactly one cycle, set busy=0, next state IDLE.
  - Signed multiply: negate the 2*WIDTH product when the operand signs differ.
  - Signed divide: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
- Latency: start sampled at edge E0, so busy=1 after E0; CALC covers E1..E32 and FINISH ends at E33.
  - Result, done=1 and busy=0 are all visible after E33; busy is high for 33 cycles.
  - A new start is accepted on E34, the edge where done drops.
- While busy=1: start, hi_we and lo_we are ignored; a and b may change freely (already latched).
- Divide by zero (b=0, DIV or DIVU): full latency, then lo=all ones (0xFFFFFFFF) and hi=a.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Arithmetic: products are exact to 2*WIDTH bits; no saturation.

Test Plan:
- Reset low mid-CALC of a MULTU -> busy=0, done=0, hi=lo=0 immediately; no done pulse after reset releases.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 -> busy high for 33 cycles; after E33 hi=0xFFFFFFFE, lo=0x00000001, done high exactly one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
- Idle: hi_we=1 with a=0xAAAA5555 -> hi=0xAAAA5555, lo unchanged.
  - start plus lo_we in the same cycle -> lo not written by MTLO.
  - start pulsed again while busy -> ignored, original result delivered.
